store_unit: RTL

//  Parametrised successor to the S-type byte-enable decoder. Sits between the execute stage and the

---
 rtl/store_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/store_unit.sv
// Store unit: registers one S-type store per handshake, then drives byte strobes and lane-shifted data
// onto a valid/ready memory port. Define MISALIGN_SPLIT_EN to split bus-word-crossing stores into two beats.
module store_unit #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [2:0]        funct3,
   input  logic [31:0]       addr,
   input  logic [XLEN-1:0]   wdata,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [31:0]       mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_we,
   output logic              st_done,
   output logic              st_fault
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);
   localparam int MW = 2 * NB;

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

   state_t            state, state_nx;
   logic [1:0]        size_q;
   logic [31:0]       addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic              fault_q;

   logic              accept;
   logic              illegal;
   logic              misalign;
   logic [OW-1:0]     off;
   logic [MW-1:0]     lane_base;
   logic [MW-1:0]     mask2;
   logic [2*XLEN-1:0] wide;
   logic [31:0]       base_addr;

   assign accept  = st_valid && st_ready;
   assign illegal = funct3[2] || ((XLEN == 32) && (funct3[1:0] == 2'b11));

`ifdef MISALIGN_SPLIT_EN
   logic cross;
   assign misalign = 1'b0;
   assign cross    = |mask2[MW-1:NB];
`else
   logic [OW-1:0] align_mask;
   assign align_mask = OW'((32'd1 << funct3[1:0]) - 32'd1);
   assign misalign   = |(addr[OW-1:0] & align_mask);
`endif

   // Strobes and data are built as a double-width window; the upper half is the second beat.
   assign off       = addr_q[OW-1:0];
   assign lane_base = MW'((32'd1 << (32'd1 << size_q)) - 32'd1);
   assign mask2     = lane_base << off;
   assign wide      = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
   assign base_addr = {addr_q[31:OW], {OW{1'b0}}};

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: the captured request is reset with the FSM so every output is a clean 0 out of reset.
      if (reset) begin
         state   <= IDLE;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            size_q  <= funct3[1:0];
            addr_q  <= addr;
            wdata_q <= wdata;
            fault_q <= illegal || misalign;
         end
      end
   end

   always_comb begin
      // NOTE: every output and the next state get a default first, so no branch can infer a latch.
      state_nx  = state;
      st_ready  = 1'b0;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = '0;
      st_done   = 1'b0;
      st_fault  = 1'b0;
      unique case (state)
         IDLE: begin
            st_ready = !reset;
            if (st_valid && !reset)
               state_nx = (illegal || misalign) ? RESP : BEAT0;
         end
         BEAT0: begin
            mem_valid = 1'b1;
            mem_addr  = base_addr;
            mem_we    = mask2[NB-1:0];
            mem_wdata = wide[XLEN-1:0];
            if (mem_ready) begin
`ifdef MISALIGN_SPLIT_EN
               state_nx = cross ? BEAT1 : RESP;
`else
               state_nx = RESP;
`endif
            end
         end
         BEAT1: begin
            mem_valid = 1'b1;
            mem_addr  = base_addr + 32'(NB);
            mem_we    = mask2[MW-1:NB];
            mem_wdata = wide[2*XLEN-1:XLEN];
            if (mem_ready)
               state_nx = RESP;
         end
         RESP: begin
            st_done  = 1'b1;
            st_fault = fault_q;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
